multi_frequency_counter: RTL and testbench

Parametrised, multi-channel successor to the single-channel frequency counter. It counts rising edges on up to CHANNELS asynchronous input signals over a common gate window of GATE_CYCLES clock cycles. At the end of each window it publishes every channel's count simultaneously with a one-cycle Valid strobe. It adds input synchronisation, an enable control, back-to-back gap-free windows and optional overflow saturation, and sits between external test/measurement pins and the readout logic.

---
 rtl/multi_frequency_counter.sv | 223 ++++++++++++++++++++++
 tb/tb_multi_frequency_counter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_frequency_counter.sv
// ============================================================================
// multi_frequency_counter
// ----------------------------------------------------------------------------
// Counts rising edges on CHANNELS asynchronous inputs over a common gate
// window of GATE_CYCLES clock cycles.  When a window ends, every channel's
// count is published at the same time on Freq, and Valid pulses for one
// cycle.  Windows follow each other with no gap, so no edge is lost at a
// window boundary.  Dropping Enable discards the window in progress.
//
// Parameters
//   CHANNELS     number of independent input channels (>= 1)
//   CNT_WIDTH    width of each channel counter and result (>= 2)
//   GATE_CYCLES  gate window length in Clk cycles (>= 2)
//   SYNC_STAGES  synchroniser depth per channel (>= 2)
//
// Ports
//   Clk     in   system clock, rising edge
//   Rst_n   in   asynchronous active-low reset
//   Enable  in   1 = run measurement windows, 0 = idle and discard partial window
//   Sig     in   [CHANNELS] asynchronous inputs, bit i = channel i
//   Freq    out  [CHANNELS*CNT_WIDTH] latched counts, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   Valid   out  one-cycle strobe on the cycle Freq/Ovf take new values
//   Ovf     out  [CHANNELS] per-channel overflow flag for the latched window
//
// Build option
//   FREQCNT_SATURATE_EN  when defined, counters saturate at all-ones and a
//                        sticky per-channel flag is reported on Ovf.  When
//                        undefined, counters wrap and Ovf is tied low.
// ============================================================================
module multi_frequency_counter #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned GATE_CYCLES = 100000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic                          Enable,
    input  logic [CHANNELS-1:0]           Sig,
    output logic [CHANNELS*CNT_WIDTH-1:0] Freq,
    output logic                          Valid,
    output logic [CHANNELS-1:0]           Ovf
);

    localparam int unsigned     GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t state;
    state_t state_next;

    // ------------------------------------------------------------------------
    // Input synchronisers and rising-edge detectors
    // ------------------------------------------------------------------------
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_prev;
    logic [CHANNELS-1:0] edge_det;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            sync_prev <= '0;
        end else begin
            sync_q[0] <= Sig;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync_q[SYNC_STAGES-1] & ~sync_prev;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Enable)  state_next = COUNT;
            COUNT:   if (!Enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    //   at_terminal - last cycle of the window; results are latched here even
    //                 when Enable drops on this same cycle.
    //   advance     - window continues into the next cycle.
    // ------------------------------------------------------------------------
    logic [GATE_W-1:0] gate_cnt;
    logic              at_terminal;
    logic              advance;

    always_comb begin
        at_terminal = 1'b0;
        advance     = 1'b0;
        case (state)
            COUNT: begin
                at_terminal = (gate_cnt == GATE_LAST);
                advance     = Enable && (gate_cnt != GATE_LAST);
            end
            default: begin
                at_terminal = 1'b0;
                advance     = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Gate counter: runs 0..GATE_CYCLES-1, returns to 0 at the terminal cycle
    // (next window starts immediately), on abort and while idle.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            gate_cnt <= '0;
        end else if (advance) begin
            gate_cnt <= gate_cnt + GATE_W'(1);
        end else begin
            gate_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Channel counters
    //   cnt_sum is the count including this cycle's edge; it feeds both the
    //   running counter and the terminal-cycle latch so the edge arriving on
    //   the terminal cycle lands in the window being closed.
    // ------------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] cnt     [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_sum [CHANNELS];

`ifdef FREQCNT_SATURATE_EN
    logic [CHANNELS-1:0] sat_hit;   // increment attempted at all-ones this cycle
    logic [CHANNELS-1:0] sticky;    // saturation seen earlier in this window

    always_comb begin
        sat_hit = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (edge_det[i] && (cnt[i] == '1)) begin
                cnt_sum[i] = cnt[i];
                sat_hit[i] = 1'b1;
            end else begin
                cnt_sum[i] = cnt[i] + CNT_WIDTH'(edge_det[i]);
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sticky <= '0;
        end else if (advance) begin
            sticky <= sticky | sat_hit;
        end else begin
            sticky <= '0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Ovf <= '0;
        end else if (at_terminal) begin
            Ovf <= sticky | sat_hit;
        end
    end
`else
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_sum[i] = cnt[i] + CNT_WIDTH'(edge_det[i]);
        end
    end

    assign Ovf = '0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt[i] <= advance ? cnt_sum[i] : '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Result latch and Valid strobe
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Freq  <= '0;
            Valid <= 1'b0;
        end else begin
            Valid <= at_terminal;
            if (at_terminal) begin
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    Freq[i*CNT_WIDTH +: CNT_WIDTH] <= cnt_sum[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_frequency_counter.sv
// ============================================================================
// tb_multi_frequency_counter
// Two instances share the stimulus: a 32-bit-counter instance and a 4-bit
// instance used for the overflow behaviour.  A window-level reference model
// (list of sampled rising edges, summed over each window's range of cycles)
// is checked on every falling clock edge; table rows and hand-written
// sequences add fixed expected values for the steady-state and corner cases.
// ============================================================================
module tb_multi_frequency_counter;

    localparam int G    = 100;
    localparam int S    = 2;
    localparam int MAXC = 40000;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  sig    = 2'b00;
    logic [63:0] freq;
    logic        valid;
    logic [1:0]  ovf;
    logic [7:0]  freq4;
    logic        valid4;
    logic [1:0]  ovf4;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    multi_frequency_counter #(
        .CHANNELS(2), .CNT_WIDTH(32), .GATE_CYCLES(G), .SYNC_STAGES(S)
    ) dut (
        .Clk(clk), .Rst_n(rst_n), .Enable(enable), .Sig(sig),
        .Freq(freq), .Valid(valid), .Ovf(ovf)
    );

    multi_frequency_counter #(
        .CHANNELS(2), .CNT_WIDTH(4), .GATE_CYCLES(G), .SYNC_STAGES(S)
    ) dut4 (
        .Clk(clk), .Rst_n(rst_n), .Enable(enable), .Sig(sig),
        .Freq(freq4), .Valid(valid4), .Ovf(ovf4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected 4-bit-counter result for a window holding n edges.
    function automatic int w4(input int n);
`ifdef FREQCNT_SATURATE_EN
        return (n > 15) ? 15 : n;
`else
        return n % 16;
`endif
    endfunction

    function automatic int ovf4_of(input int n);
`ifdef FREQCNT_SATURATE_EN
        return (n > 15) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus driver: changes sig 1 time unit after each rising edge
    // ------------------------------------------------------------------------
    typedef enum {M_MANUAL, M_PERIODIC, M_RANDOM} mode_t;
    mode_t      mode    = M_MANUAL;
    logic [1:0] man_sig = 2'b00;
    int         per [2] = '{20, 10};

    initial begin
        int ph [2];
        ph = '{0, 0};
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                M_PERIODIC: begin
                    for (int c = 0; c < 2; c++) begin
                        sig[c] = ((ph[c] % per[c]) < (per[c] / 2));
                        ph[c]++;
                    end
                end
                M_RANDOM: sig = 2'($urandom);
                default:  sig = man_sig;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Reference model.  A rise seen in the input sampled at edge n is counted
    // at edge n+S.  A window started by Enable sampled at edge t0 covers the
    // count edges t0+1 .. t0+G and is published at edge t0+G, then repeats.
    // ------------------------------------------------------------------------
    int         rises [2][MAXC];
    int         cyc     = 0;
    int         t0      = 0;
    bit         running = 1'b0;
    logic [1:0] last_s  = 2'b00;
    bit         exp_valid = 1'b0;
    int         exp_f  [2] = '{0, 0};
    int         exp_f4 [2] = '{0, 0};
    int         exp_o4 [2] = '{0, 0};

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            exp_valid = 1'b0;
            if (!rst_n) begin
                running = 1'b0;
                last_s  = 2'b00;
                for (int c = 0; c < 2; c++) begin
                    for (int k = 0; k < 4; k++) rises[c][cyc+k] = 0;
                    exp_f[c]  = 0;
                    exp_f4[c] = 0;
                    exp_o4[c] = 0;
                end
            end else begin
                for (int c = 0; c < 2; c++) begin
                    if (sig[c] && !last_s[c]) rises[c][cyc+S]++;
                end
                last_s = sig;
                if (!running) begin
                    if (enable) begin
                        running = 1'b1;
                        t0      = cyc;
                    end
                end else begin
                    if (((cyc - t0) % G) == 0) begin
                        for (int c = 0; c < 2; c++) begin
                            int n;
                            n = 0;
                            for (int t = cyc - G + 1; t <= cyc; t++) n += rises[c][t];
                            exp_f[c]  = n;
                            exp_f4[c] = w4(n);
                            exp_o4[c] = ovf4_of(n);
                        end
                        exp_valid = 1'b1;
                    end
                    if (!enable) running = 1'b0;
                end
            end
        end
    end

    // Continuous comparison against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_valid", valid, 0);
                check("rst_freq", freq, 0);
                check("rst_ovf", ovf, 0);
                check("rst_freq4", freq4, 0);
                check("rst_ovf4", ovf4, 0);
            end else begin
                check("m_valid", valid, exp_valid);
                check("m_valid4", valid4, exp_valid);
                check("m_freq0", freq[31:0], exp_f[0]);
                check("m_freq1", freq[63:32], exp_f[1]);
                check("m_ovf", ovf, 0);
                check("m_freq4_0", freq4[3:0], exp_f4[0]);
                check("m_freq4_1", freq4[7:4], exp_f4[1]);
                check("m_ovf4_0", ovf4[0], exp_o4[0]);
                check("m_ovf4_1", ovf4[1], exp_o4[1]);
            end
        end
    end

    // Waits (bounded) for Valid, sampling 1 unit after each rising edge.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!valid && n < 1000);
        if (!valid) begin
            tests++;
            failed++;
            $display("FAIL valid_timeout: actual no Valid in %0d cycles required Valid", n);
        end
    endtask

    typedef struct {
        int per0;
        int per1;
        int f0;
        int f1;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int n;
        tbl[0] = '{20, 10, 5, 10};
        tbl[1] = '{4, 50, 25, 2};
        tbl[2] = '{2, 100, 50, 1};
        tbl[3] = '{25, 5, 4, 20};

        // Reset, then idle with Enable low.
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", valid, 0);
        check("reset_freq", freq, 0);
        check("reset_ovf", ovf, 0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_valid", valid, 0);
        check("idle_freq", freq, 0);

        // Periodic inputs: steady-state windows carry exact counts.
        mode = M_PERIODIC;
        for (int r = 0; r < 4; r++) begin
            enable = 1'b0;
            per[0] = tbl[r].per0;
            per[1] = tbl[r].per1;
            repeat (3) @(posedge clk);
            #1;
            enable = 1'b1;
            wait_valid(n);
            for (int w = 1; w < 4; w++) begin
                wait_valid(n);
                check("tbl_gap", n, G);
                check("tbl_freq0", freq[31:0], tbl[r].f0);
                check("tbl_freq1", freq[63:32], tbl[r].f1);
                check("tbl_freq4_0", freq4[3:0], w4(tbl[r].f0));
                check("tbl_ovf4_0", ovf4[0], ovf4_of(tbl[r].f0));
                check("tbl_ovf4_1", ovf4[1], ovf4_of(tbl[r].f1));
            end
        end

        // Abort mid-window: no Valid, results held, fresh window on re-enable.
        enable = 1'b0;
        per[0] = 20;
        per[1] = 10;
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b1;
        repeat (3) wait_valid(n);
        check("pre_abort_freq0", freq[31:0], 5);
        repeat (50) @(posedge clk);
        #1;
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("abort_valid", valid, 0);
            check("abort_freq0", freq[31:0], 5);
            check("abort_freq1", freq[63:32], 10);
        end
        enable = 1'b1;
        wait_valid(n);
        // one edge to register Enable into COUNT, then a full window
        check("reenable_latency", n, G + 1);
        check("reenable_freq0", freq[31:0], 5);
        check("reenable_freq1", freq[63:32], 10);

        // Enable dropped on the terminal cycle: window still published.
        repeat (99) @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("term_drop_valid", valid, 1);
        check("term_drop_freq1", freq[63:32], 10);
        n = 0;
        for (int k = 0; k < 120; k++) begin
            @(posedge clk);
            #1;
            if (valid) n++;
        end
        check("term_drop_no_more_valid", n, 0);

        // Window boundary: edges counted on gate 99 of one window and on
        // gates 0 and 1 of the next.
        mode    = M_MANUAL;
        man_sig = 2'b00;
        repeat (6) @(posedge clk);
        #1;
        enable = 1'b1;
        for (int k = 1; k <= 101; k++) begin
            @(posedge clk);
            case (k)
                98:      man_sig = 2'b01;
                99:      man_sig = 2'b10;
                100:     man_sig = 2'b01;
                default: man_sig = 2'b00;
            endcase
        end
        #1;
        check("bnd_valid", valid, 1);
        check("bnd_win1_freq0", freq[31:0], 1);
        check("bnd_win1_freq1", freq[63:32], 0);
        wait_valid(n);
        check("bnd_gap", n, G);
        check("bnd_win2_freq0", freq[31:0], 1);
        check("bnd_win2_freq1", freq[63:32], 1);

        // Reset in the middle of a window.
        enable = 1'b0;
        mode   = M_PERIODIC;
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b1;
        repeat (71) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_freq", freq, 0);
        check("midrst_valid", valid, 0);
        check("midrst_freq4", freq4, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        wait_valid(n);
        check("post_rst_latency", n, G + 1);

        // Random inputs and Enable against the model.
        mode = M_RANDOM;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            if (enable) begin
                if ($urandom_range(299, 0) == 0) enable = 1'b0;
            end else if ($urandom_range(4, 0) == 0) begin
                enable = 1'b1;
            end
        end
        enable = 1'b0;
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
